// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit:
// NOP encoding, ctrl hold levels, fetch FSM states and the FIFO entry layout.
package if_prefetch_pkg;

   localparam logic [31:0] NopInst = 32'h0000_0013;

   // Hold levels from ctrl; a higher level stalls more of the front end.
   localparam logic [2:0] HoldNone = 3'd0;
   localparam logic [2:0] HoldPc   = 3'd1;
   localparam logic [2:0] HoldIf   = 3'd2;
   localparam logic [2:0] HoldId   = 3'd3;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWait    = 2'd1,
      StDiscard = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small power-of-two FIFO with synchronous flush; storage is not reset, so
// consumers must qualify rdata with empty.
module if_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: issues one bus request at a time from fetch_pc, queues
// returned words in if_fifo and handles ctrl redirects and hold levels.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_ack_i,
   input  logic [31:0] ibus_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OccW = CntW + 1;
   localparam int unsigned EntW = $bits(fetch_entry_t);

   fetch_state_e     state_q;
   logic [31:0]      fetch_pc_q;
   logic             req_q;
   logic [31:0]      addr_q;

   logic [31:0]      jump_pc;
   logic [31:0]      next_pc;
   logic             unused_jump_lsb;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [CntW-1:0]  fifo_count;
   logic [OccW-1:0]  occ_next;
   logic             can_issue;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;
   logic [EntW-1:0]  head_raw;

   assign jump_pc         = {jump_addr_i[31:2], 2'b00};
   assign unused_jump_lsb = ^jump_addr_i[1:0];
   assign next_pc         = fetch_pc_q + 32'd4;

   assign fifo_pop  = !fifo_empty && (hold_flag_i < HoldIf) && !jump_flag_i;
   assign fifo_push = (state_q == StWait) && ibus_ack_i && !jump_flag_i &&
                      (!fifo_full || fifo_pop);

   // Occupancy after this edge; a newly issued request reserves one more slot.
   assign occ_next  = {1'b0, fifo_count} + OccW'(fifo_push) - OccW'(fifo_pop);
   assign can_issue = (hold_flag_i < HoldPc) && !jump_flag_i &&
                      (occ_next < OccW'(FIFO_DEPTH));

   assign push_entry = '{addr: addr_q, inst: ibus_data_i};
   assign head_entry = fetch_entry_t'(head_raw);

   if_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EntW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (jump_flag_i),
      .wdata (push_entry),
      .rdata (head_raw),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= 32'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_pc;
               end else if (can_issue) begin
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_pc;
                  if (ibus_ack_i) begin
                     req_q   <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StDiscard;
                  end
               end else if (ibus_ack_i) begin
                  fetch_pc_q <= next_pc;
                  if (can_issue) begin
                     addr_q <= next_pc;
                  end else begin
                     req_q   <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            StDiscard: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_pc;
               end
               // The redirected fetch starts from IDLE, never on the ack edge.
               if (ibus_ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ibus_req_o   = req_q;
   assign ibus_addr_o  = addr_q;
   assign inst_valid_o = !fifo_empty;
   assign inst_o       = fifo_empty ? NopInst : head_entry.inst;
   assign inst_addr_o  = fifo_empty ? 32'h0 : head_entry.addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch with default parameters.
module tb_if_prefetch;

   logic        clk;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic [2:0]  hold_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i;
   logic [31:0] ibus_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   int checks = 0;
   int errors = 0;

   if_prefetch dut (
      .clk          (clk),
      .rst          (rst),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .hold_flag_i  (hold_flag_i),
      .ibus_req_o   (ibus_req_o),
      .ibus_addr_o  (ibus_addr_o),
      .ibus_ack_i   (ibus_ack_i),
      .ibus_data_i  (ibus_data_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word the bench's memory returns for a given address.
   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      jump_flag_i = 1'b0;
      jump_addr_i = 32'h0;
      hold_flag_i = 3'd0;
      ibus_ack_i  = 1'b0;
      ibus_data_i = 32'h0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic ack(input logic [31:0] a);
      ibus_ack_i  = 1'b1;
      ibus_data_i = mk(a);
   endtask

   task automatic no_ack();
      ibus_ack_i  = 1'b0;
      ibus_data_i = 32'h0;
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      jump_flag_i = 1'b0;
      jump_addr_i = 32'h0;
      hold_flag_i = 3'd0;
      no_ack();
      tick();
      tick();
      checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", ibus_req_o); end
      checks++; if (ibus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", ibus_addr_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid_o); end
      checks++; if (inst_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_inst got %h exp 00000013", inst_o); end
      checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %h exp 0", inst_addr_o); end
   endtask

   task automatic test_sequential();
      do_reset();
      tick();
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin errors++; $display("FAIL seq_req0 got %b/%h exp 1/0", ibus_req_o, ibus_addr_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL seq_valid_early got %b exp 0", inst_valid_o); end
      ack(32'h0);
      tick();
      checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL seq_head0 got %b/%h exp 1/0", inst_valid_o, inst_addr_o); end
      checks++; if (inst_o !== mk(32'h0)) begin errors++; $display("FAIL seq_inst0 got %h exp %h", inst_o, mk(32'h0)); end
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4) begin errors++; $display("FAIL seq_req4 got %b/%h exp 1/4", ibus_req_o, ibus_addr_o); end
      ack(32'h4);
      tick();
      checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4) begin errors++; $display("FAIL seq_head4 got %b/%h exp 1/4", inst_valid_o, inst_addr_o); end
      checks++; if (ibus_addr_o !== 32'h8) begin errors++; $display("FAIL seq_req8 got %h exp 8", ibus_addr_o); end
      ack(32'h8);
      tick();
      checks++; if (inst_addr_o !== 32'h8 || inst_o !== mk(32'h8)) begin errors++; $display("FAIL seq_head8 got %h/%h exp 8/%h", inst_addr_o, inst_o, mk(32'h8)); end
      checks++; if (ibus_addr_o !== 32'hC) begin errors++; $display("FAIL seq_reqC got %h exp c", ibus_addr_o); end
      no_ack();
   endtask

   task automatic test_hold();
      do_reset();
      tick();
      ack(32'h0);
      tick();
      hold_flag_i = 3'd2;
      ack(32'h4);
      checks++; if (ibus_addr_o !== 32'h4 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL hold_setup got %h/%h exp 4/0", ibus_addr_o, inst_addr_o); end
      tick();
      no_ack();
      checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL hold_req_stop got %b exp 0", ibus_req_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL hold_stall%0d got %b/%b/%h exp 0/1/0", i, ibus_req_o, inst_valid_o, inst_addr_o); end
      end
      hold_flag_i = 3'd0;
      tick();
      checks++; if (inst_addr_o !== 32'h4 || inst_o !== mk(32'h4)) begin errors++; $display("FAIL hold_head4 got %h/%h exp 4/%h", inst_addr_o, inst_o, mk(32'h4)); end
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8) begin errors++; $display("FAIL hold_req8 got %b/%h exp 1/8", ibus_req_o, ibus_addr_o); end
      hold_flag_i = 3'd2;
      ack(32'h8);
      tick();
      no_ack();
      checks++; if (inst_addr_o !== 32'h4 || ibus_req_o !== 1'b0) begin errors++; $display("FAIL hold_refill got %h/%b exp 4/0", inst_addr_o, ibus_req_o); end
      hold_flag_i = 3'd0;
      tick();
      checks++; if (inst_addr_o !== 32'h8 || ibus_addr_o !== 32'hC) begin errors++; $display("FAIL hold_resume got %h/%h exp 8/c", inst_addr_o, ibus_addr_o); end
   endtask

   task automatic test_jump_wait();
      do_reset();
      tick();
      ack(32'h0);
      tick();
      ack(32'h4);
      tick();
      no_ack();
      checks++; if (ibus_addr_o !== 32'h8 || inst_addr_o !== 32'h4) begin errors++; $display("FAIL jw_setup got %h/%h exp 8/4", ibus_addr_o, inst_addr_o); end
      tick();
      checks++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b1) begin errors++; $display("FAIL jw_waiting got %b/%b exp 0/1", inst_valid_o, ibus_req_o); end
      jump_flag_i = 1'b1;
      jump_addr_i = 32'h100;
      tick();
      jump_flag_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL jw_discard%0d got %b/%h/%b exp 1/8/0", i, ibus_req_o, ibus_addr_o, inst_valid_o); end
         if (i == 2) ack(32'h8);
         tick();
      end
      no_ack();
      checks++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL jw_dropped got %b/%b exp 0/0", ibus_req_o, inst_valid_o); end
      tick();
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) begin errors++; $display("FAIL jw_target got %b/%h exp 1/100", ibus_req_o, ibus_addr_o); end
      ack(32'h100);
      tick();
      no_ack();
      checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== mk(32'h100)) begin errors++; $display("FAIL jw_head got %b/%h/%h exp 1/100/%h", inst_valid_o, inst_addr_o, inst_o, mk(32'h100)); end
   endtask

   task automatic test_jump_ack();
      do_reset();
      tick();
      ack(32'h0);
      jump_flag_i = 1'b1;
      jump_addr_i = 32'h203;
      tick();
      jump_flag_i = 1'b0;
      no_ack();
      checks++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL ja_drop got %b/%b exp 0/0", ibus_req_o, inst_valid_o); end
      tick();
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h200) begin errors++; $display("FAIL ja_target got %b/%h exp 1/200", ibus_req_o, ibus_addr_o); end
      ack(32'h200);
      tick();
      no_ack();
      checks++; if (inst_addr_o !== 32'h200 || ibus_addr_o !== 32'h204) begin errors++; $display("FAIL ja_next got %h/%h exp 200/204", inst_addr_o, ibus_addr_o); end
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      jump_flag_i = 1'b1;
      jump_addr_i = 32'hFFFF_FFFC;
      tick();
      jump_flag_i = 1'b0;
      ack(32'h0);
      tick();
      no_ack();
      tick();
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %b/%h exp 1/fffffffc", ibus_req_o, ibus_addr_o); end
      ack(32'hFFFF_FFFC);
      tick();
      no_ack();
      checks++; if (ibus_addr_o !== 32'h0 || inst_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_zero got %h/%h exp 0/fffffffc", ibus_addr_o, inst_addr_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      ack(32'h0);
      jump_flag_i = 1'b1;
      jump_addr_i = 32'h3C;
      tick();
      jump_flag_i = 1'b0;
      no_ack();
      tick();
      ack(32'h3C);
      tick();
      no_ack();
      checks++; if (ibus_addr_o !== 32'h40 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL rm_setup got %h/%b exp 40/1", ibus_addr_o, inst_valid_o); end
      #1 rst = 1'b0;
      #1;
      checks++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) begin errors++; $display("FAIL rm_bus got %b/%h exp 0/0", ibus_req_o, ibus_addr_o); end
      checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0013 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL rm_head got %b/%h/%h exp 0/00000013/0", inst_valid_o, inst_o, inst_addr_o); end
      do_reset();
      tick();
      checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin errors++; $display("FAIL rm_restart got %b/%h exp 1/0", ibus_req_o, ibus_addr_o); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_hold();
      test_jump_wait();
      test_jump_ack();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, reset; asynchronous assert, active-low; the block has one clock.
- jump_flag_i, in, 1, redirect request from ctrl.
- jump_addr_i, in, 32, redirect target from ctrl.
- hold_flag_i, in, 3, ctrl hold level: 0 None, 1 Pc, 2 If, 3 Id.
- ibus_req_o, out, 1, instruction bus request.
- ibus_addr_o, out, 32, request address.
- ibus_ack_i, in, 1, request done; ibus_data_i valid this cycle.
- ibus_data_i, in, 32, fetched instruction word.
- inst_valid_o, out, 1, FIFO head valid.
- inst_o, out, 32, head instruction; 32'h0000_0013 (NOP) when not valid.
- inst_addr_o, out, 32, head instruction address; 0 when not valid.

Function
REQ-003 The block SHALL hold fetch_pc, a FIFO of {addr, inst} entries, and an FSM with states IDLE, WAIT and DISCARD.
REQ-004 In IDLE, the block SHALL assert ibus_req_o with ibus_addr_o=fetch_pc and move to WAIT when all of these hold: free entries >0, hold_flag_i<1, and jump_flag_i=0.
REQ-005 In WAIT and DISCARD, ibus_req_o SHALL remain high with ibus_addr_o stable until ibus_ack_i; a request SHALL never be withdrawn, and at most one SHALL be outstanding.
REQ-006 On ack in WAIT without jump, the block SHALL push {ibus_addr_o, ibus_data_i}, set fetch_pc+=4 (32-bit wrap 32'hFFFF_FFFC->0), and go to IDLE.
- The same-cycle issue-after-ack (back-to-back) SHALL be permitted when REQ-004 holds for the next address.
REQ-007 The block SHALL pop the head when inst_valid_o=1 and hold_flag_i<2; a simultaneous push and pop SHALL leave the count unchanged.
REQ-008 The issue condition SHALL count the outstanding request as occupied, so the FIFO never overflows; pop on empty SHALL have no effect.
REQ-009 When jump_flag_i=1, the block SHALL flush the FIFO and load fetch_pc={jump_addr_i[31:2],2'b00} in that cycle; jump SHALL override push, pop and issue.
- Jump in WAIT without ack: go to DISCARD.
- Jump in WAIT with ack: drop the data and go to IDLE.
- Jump in DISCARD: update fetch_pc and stay in DISCARD.
REQ-010 In DISCARD, the block SHALL drop the data on ack and go to IDLE; it SHALL issue the redirected request no earlier than the cycle after the ack.
REQ-011 Latency SHALL be as follows:
- First request: the first clock edge after reset release.
- inst_valid_o: rises the cycle after the ack is sampled.
- Redirect: the first request for the jump target issues the cycle after the jump when IDLE.
REQ-012 inst_o and inst_addr_o SHALL be driven from FIFO storage with no combinational path from ibus_data_i.

Reset
REQ-013 While rst=0, the block SHALL hold: FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, ibus_req_o=0, ibus_addr_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0.
REQ-014 Reset asserted mid-request SHALL abandon the transaction, and the bus SHALL tolerate a dropped request.

Structure
REQ-015 The NOP encoding, hold-level codes, and FSM state encodings SHALL live in the shared defines include; RESET_PC and FIFO_DEPTH SHALL stay parameters.
REQ-016 The FIFO SHALL be one sub-module, if_fifo, parameterised by depth and width with push/pop/flush, count, empty, and full; the FSM and fetch_pc SHALL stay in if_prefetch.

Verification
REQ-017 Reset release, ack after 1 cycle each, hold=0 -> requests 0x0, 0x4, 0x8; inst_addr_o sequence 0x0, 0x4, 0x8; first inst_valid_o 2 cycles after reset release.
REQ-018 hold_flag_i=2 held with 1-cycle acks -> exactly 2 entries fill (0x0, 0x4); ibus_req_o low until hold=0; no entry lost or duplicated.
REQ-019 Jump to 0x100 while WAIT at 0x8, ack 3 cycles later -> data for 0x8 dropped; next request at 0x100; FIFO empty in between.
REQ-020 Jump to 0x203 coincident with ack -> ack data dropped; next request at 0x200.
REQ-021 fetch_pc at 0xFFFF_FFFC, ack -> next request at 0x0000_0000.
REQ-022 rst low during WAIT at 0x40 -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC.
